// File: rtl/mm_ctrl_pkg.sv
// Shared types and sizing helpers for the matrix-multiply job sequencer.
// Pure declarations, no logic; sized for the default 8x8 / 4-lane configuration.
package mm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_OVERRUN   = 2'd2,
        ERR_DRAIN_LEN = 2'd3
    } err_code_t;

    localparam int DEF_M       = 8;
    localparam int DEF_N1      = 4;
    localparam int DEF_TIMEOUT = 4096;
    localparam int RES_TOTAL   = DEF_M * DEF_M;
    localparam int RES_W       = $clog2(RES_TOTAL) + 1;
    localparam int JOBS_W      = 8;

    function automatic int cnt_width(input int total);
        return $clog2(total) + 1;
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mm_phase_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear, flags the TIMEOUT-th.
// Latency: expire is combinational from the count, asserted in the TIMEOUT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module mm_phase_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expire = en && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mm_job_ctrl.sv
// Job sequencer: runs K load/compute/drain jobs per command with beat counting and a watchdog.
// Latency: all outputs registered; start pulses land on the first cycle of each new phase.
// Backpressure: commands only accepted in IDLE (s_cmd_ready); stream taps are observed, never stalled.
module mm_job_ctrl
    import mm_ctrl_pkg::*;
#(
    parameter int M       = DEF_M,
    parameter int N1      = DEF_N1,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_cmd_valid,
    output logic          s_cmd_ready,
    input  logic [7:0]    s_cmd_jobs,
    output logic          load_start,
    input  logic          load_done,
    output logic          compute_start,
    input  logic [N1-1:0] valid_D,
    output logic          drain_start,
    input  logic          mon_tvalid,
    input  logic          mon_tready,
    input  logic          mon_tlast,
    input  logic          err_clr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    jobs_left
);
    localparam int RES_N = M * M;
    localparam int CNT_W = cnt_width(RES_N);
    // Sum is wide enough for a near-full count plus every lane firing at once.
    localparam int SUM_W = cnt_width(RES_N + N1);

    state_t           state_q, state_d;
    err_code_t        err_nxt, err_code_q, err_code_d;
    logic [CNT_W-1:0] res_cnt, beat_cnt, beat_nxt;
    logic [SUM_W-1:0] res_sum;
    logic             cmd_acc, beat_hs, job_end, expire, phase_clr, phase_en;
    logic             s_cmd_ready_d, busy_d, done_d, err_d;
    logic             load_start_d, compute_start_d, drain_start_d;
    logic [7:0]       jobs_left_d;

    assign res_sum   = SUM_W'(res_cnt) + SUM_W'(popcount(64'(valid_D)));
    assign beat_hs   = (state_q == ST_DRAIN) && mon_tvalid && mon_tready;
    assign beat_nxt  = beat_cnt + CNT_W'(1);
    assign phase_clr = (state_d != state_q);
    assign phase_en  = (state_q == ST_LOAD) || (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);

    mm_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (phase_clr),
        .en     (phase_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion and data-integrity checks take priority over the watchdog.
    always_comb begin
        state_d = state_q;
        err_nxt = ERR_NONE;
        cmd_acc = 1'b0;
        job_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_cmd_valid && s_cmd_ready) begin
                    cmd_acc = 1'b1;
                    if (s_cmd_jobs != 8'd0) state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_COMPUTE;
                end else if (expire) begin
                    state_d = ST_ERR;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_COMPUTE: begin
                if (res_sum == SUM_W'(RES_N)) begin
                    state_d = ST_DRAIN;
                end else if (res_sum > SUM_W'(RES_N)) begin
                    state_d = ST_ERR;
                    err_nxt = ERR_OVERRUN;
                end else if (expire) begin
                    state_d = ST_ERR;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (beat_hs && mon_tlast && (beat_nxt == CNT_W'(RES_N))) begin
                    job_end = 1'b1;
                    state_d = (jobs_left > 8'd1) ? ST_LOAD : ST_IDLE;
                end else if (beat_hs && (mon_tlast || (beat_nxt == CNT_W'(RES_N)))) begin
                    state_d = ST_ERR;
                    err_nxt = ERR_DRAIN_LEN;
                end else if (expire) begin
                    state_d = ST_ERR;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_ERR: begin
                if (err_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_cmd_ready_d   = (state_d == ST_IDLE);
        busy_d          = (state_d == ST_LOAD) || (state_d == ST_COMPUTE) || (state_d == ST_DRAIN);
        load_start_d    = (state_d == ST_LOAD) && (state_q != ST_LOAD);
        compute_start_d = (state_d == ST_COMPUTE) && (state_q != ST_COMPUTE);
        drain_start_d   = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);
        err_d           = (state_d == ST_ERR);
        done_d          = (cmd_acc && (s_cmd_jobs == 8'd0)) || (job_end && (state_d == ST_IDLE));
        err_code_d      = err_code_q;
        jobs_left_d     = jobs_left;
        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            err_code_d = err_nxt;
        end else if ((state_q == ST_ERR) && (state_d == ST_IDLE)) begin
            err_code_d = ERR_NONE;
        end
        if (cmd_acc) begin
            jobs_left_d = s_cmd_jobs;
        end else if (job_end) begin
            jobs_left_d = jobs_left - 8'd1;
        end else if ((state_q == ST_ERR) && (state_d == ST_IDLE)) begin
            jobs_left_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cmd_ready   <= 1'b1;
            busy          <= 1'b0;
            load_start    <= 1'b0;
            compute_start <= 1'b0;
            drain_start   <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code_q    <= ERR_NONE;
            jobs_left     <= 8'd0;
        end else begin
            s_cmd_ready   <= s_cmd_ready_d;
            busy          <= busy_d;
            load_start    <= load_start_d;
            compute_start <= compute_start_d;
            drain_start   <= drain_start_d;
            done          <= done_d;
            err           <= err_d;
            err_code_q    <= err_code_d;
            jobs_left     <= jobs_left_d;
        end
    end

    assign err_code = err_code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt  <= '0;
            beat_cnt <= '0;
        end else if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            res_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            if (state_q == ST_COMPUTE) res_cnt <= res_sum[CNT_W-1:0];
            if (beat_hs) beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_mm_job_ctrl.sv
// Randomized bench for mm_job_ctrl; expectations derive from job-level timing rules.
module tb_mm_job_ctrl;
    localparam int M       = 8;
    localparam int N1      = 4;
    localparam int TIMEOUT = 4096;
    localparam int RES     = M * M;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_cmd_valid = 1'b0;
    logic          s_cmd_ready;
    logic [7:0]    s_cmd_jobs = 8'd0;
    logic          load_start;
    logic          load_done = 1'b0;
    logic          compute_start;
    logic [N1-1:0] valid_D = '0;
    logic          drain_start;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          mon_tlast = 1'b0;
    logic          err_clr = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    jobs_left;

    int n_chk = 0;
    int n_fail = 0;
    int n_ls = 0, n_cs = 0, n_ds = 0, n_done = 0, n_busy = 0;
    int b_ls, b_cs, b_ds, b_done, b_busy;

    mm_job_ctrl #(.M(M), .N1(N1), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .s_cmd_jobs    (s_cmd_jobs),
        .load_start    (load_start),
        .load_done     (load_done),
        .compute_start (compute_start),
        .valid_D       (valid_D),
        .drain_start   (drain_start),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .mon_tlast     (mon_tlast),
        .err_clr       (err_clr),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .jobs_left     (jobs_left)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_ls   += int'(load_start);
        n_cs   += int'(compute_start);
        n_ds   += int'(drain_start);
        n_done += int'(done);
        n_busy += int'(busy);
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation time limit reached, required $finish earlier");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_D    = '0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        err_clr    = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic snap();
        b_ls = n_ls; b_cs = n_cs; b_ds = n_ds; b_done = n_done; b_busy = n_busy;
    endtask

    task automatic send_cmd(input int k);
        chk("cmd_ready", s_cmd_ready, 1);
        s_cmd_jobs  = 8'(k);
        s_cmd_valid = 1'b1;
        tick();
        s_cmd_valid = 1'b0;
        s_cmd_jobs  = 8'($urandom);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_code", err_code, 0);
        chk("clr_ready", s_cmd_ready, 1);
        chk("clr_jobs", jobs_left, 0);
    endtask

    task automatic to_drain(input int k);
        send_cmd(k);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        valid_D = '1;
        repeat (RES / N1) tick();
        valid_D = '0;
        chk("to_drain", drain_start, 1);
    endtask

    // One job from load_start to final tlast; stimulus outside the active phase is garbage.
    task automatic run_job(input int exp_left, input bit last, input int rdy_pct, input bit directed);
        int tot, beats, lat, guard;
        logic [N1-1:0] v;
        chk("load_start", load_start, 1);
        chk("busy_load", busy, 1);
        chk("jobs_left", jobs_left, exp_left);
        lat = directed ? 5 : $urandom_range(0, 6);
        for (int i = 0; i < lat; i++) begin
            if (!directed) begin
                valid_D    = N1'($urandom);
                mon_tvalid = 1'($urandom);
                mon_tready = 1'($urandom);
                mon_tlast  = 1'($urandom);
                err_clr    = 1'($urandom);
            end
            tick();
            chk("load_pulse", load_start, 0);
        end
        idle_inputs();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("compute_start", compute_start, 1);
        tot = 0;
        guard = 0;
        while (tot < RES && guard < 1000) begin
            v = directed ? '1 : N1'($urandom);
            while ($countones(v) > RES - tot) v = v & (v - N1'(1));
            valid_D = v;
            tot += $countones(v);
            if (!directed) begin
                mon_tvalid = 1'($urandom);
                mon_tready = 1'($urandom);
                mon_tlast  = 1'($urandom);
            end
            tick();
            guard++;
            if (tot < RES) chk("early_drain", drain_start, 0);
        end
        idle_inputs();
        chk("drain_start", drain_start, 1);
        beats = 0;
        guard = 0;
        while (beats < RES && guard < 2000) begin
            mon_tvalid = directed || ($urandom_range(0, 99) < 80);
            mon_tready = directed || ($urandom_range(0, 99) < rdy_pct);
            mon_tlast  = (beats == RES - 1);
            if (!directed) valid_D = N1'($urandom);
            if (mon_tvalid && mon_tready) beats++;
            tick();
            guard++;
        end
        idle_inputs();
        chk("drain_beats", beats, RES);
        chk("job_err", err, 0);
        if (last) begin
            chk("done", done, 1);
            chk("busy_end", busy, 0);
            chk("ready_end", s_cmd_ready, 1);
            chk("jobs_end", jobs_left, 0);
        end else begin
            chk("done_mid", done, 0);
        end
    endtask

    initial begin
        int k, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", s_cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_jobs", jobs_left, 0);
        chk("rst_ls", load_start, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single directed job
        snap();
        send_cmd(1);
        run_job(1, 1'b1, 100, 1'b1);
        tick();
        chk("k1_done_width", done, 0);
        chk("k1_ls", n_ls - b_ls, 1);
        chk("k1_cs", n_cs - b_cs, 1);
        chk("k1_ds", n_ds - b_ds, 1);
        chk("k1_done", n_done - b_done, 1);

        // Multi-job commands, 50% ready
        for (int r = 0; r < 4; r++) begin
            k = (r == 0) ? 3 : $urandom_range(1, 4);
            snap();
            send_cmd(k);
            for (int j = 0; j < k; j++) run_job(k - j, j == k - 1, 50, 1'b0);
            tick();
            chk("multi_done_width", done, 0);
            chk("multi_ls", n_ls - b_ls, k);
            chk("multi_cs", n_cs - b_cs, k);
            chk("multi_ds", n_ds - b_ds, k);
            chk("multi_done", n_done - b_done, 1);
        end

        // Empty command
        snap();
        send_cmd(0);
        chk("k0_done", done, 1);
        chk("k0_busy", busy, 0);
        chk("k0_ready", s_cmd_ready, 1);
        tick();
        chk("k0_done_width", done, 0);
        repeat (3) tick();
        chk("k0_ls", n_ls - b_ls, 0);
        chk("k0_busy_cycles", n_busy - b_busy, 0);
        chk("k0_done_cnt", n_done - b_done, 1);

        // Load watchdog
        send_cmd(1);
        chk("to_ls", load_start, 1);
        n = 0;
        while (!err && n < TIMEOUT + 20) begin
            tick();
            n++;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_code", err_code, 1);
        chk("to_busy", busy, 0);
        chk("to_ready", s_cmd_ready, 0);
        chk("to_jobs", jobs_left, 1);
        repeat (3) tick();
        chk("to_sticky", err, 1);
        clear_err();

        // Result overrun
        send_cmd(1);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        valid_D = '1;
        repeat (15) tick();
        valid_D = N1'(3);
        tick();
        chk("ovr_pre", err, 0);
        valid_D = '1;
        tick();
        valid_D = '0;
        chk("ovr_err", err, 1);
        chk("ovr_code", err_code, 2);
        chk("ovr_nodrain", drain_start, 0);
        clear_err();

        // Early tlast on beat 63
        to_drain(1);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        repeat (RES - 2) tick();
        chk("tl63_pre", err, 0);
        mon_tlast = 1'b1;
        tick();
        idle_inputs();
        chk("tl63_err", err, 1);
        chk("tl63_code", err_code, 3);
        clear_err();

        // Beat 64 without tlast
        to_drain(2);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        repeat (RES) tick();
        idle_inputs();
        chk("notl_err", err, 1);
        chk("notl_code", err_code, 3);
        chk("notl_jobs", jobs_left, 2);
        clear_err();

        // Asynchronous reset mid-drain, then a normal job
        to_drain(1);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", s_cmd_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_jobs", jobs_left, 0);
        chk("arst_err", err, 0);
        chk("arst_done", done, 0);
        chk("arst_ds", drain_start, 0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        tick();
        snap();
        send_cmd(1);
        run_job(1, 1'b1, 70, 1'b0);
        tick();
        chk("post_rst_done", n_done - b_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
